// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side pointer/flag controller; optional almost-empty level under FIFO_ALMOST_EMPTY_EN
module fifo_rd_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AE_THRESH = 2
) (
  input  logic              r_clk,
  input  logic              resetn,
  input  logic              r_en,
  input  logic [ADDR_W:0]   w_gptr,
  output logic [ADDR_W-1:0] r_adrs,
  output logic              r_fire,
  output logic [ADDR_W:0]   r_gptr,
  output logic              empty,
  output logic              r_valid,
  output logic              almost_empty
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] wq1_q;
  logic [ADDR_W:0] wq2_q;
  logic [ADDR_W:0] rbin_q;
  logic [ADDR_W:0] rbin_d;
  logic [ADDR_W:0] r_gptr_q;
  logic [ADDR_W:0] r_gptr_d;
  logic            empty_q;
  logic            empty_d;
  logic            r_valid_q;

  // A read while empty is dropped here, so the pointer never moves past the write pointer.
  assign r_fire  = r_en & ~empty_q;
  assign r_adrs  = rbin_q[ADDR_W-1:0];
  assign r_gptr  = r_gptr_q;
  assign empty   = empty_q;
  assign r_valid = r_valid_q;

  // Next read pointer, its Gray image, and empty judged against the post-read pointer.
  always_comb begin
    rbin_d   = rbin_q + {{ADDR_W{1'b0}}, r_fire};
    r_gptr_d = rbin_d ^ (rbin_d >> 1);
    empty_d  = (r_gptr_d == wq2_q);
  end

  // Two-flop synchronizer bringing the write pointer into the read clock domain.
  always_ff @(posedge r_clk or negedge resetn) begin
    if (!resetn) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= w_gptr;
      wq2_q <= wq1_q;
    end
  end

  // Read pointer, Gray pointer, empty flag and data-valid registers.
  always_ff @(posedge r_clk or negedge resetn) begin
    if (!resetn) begin
      rbin_q    <= '0;
      r_gptr_q  <= '0;
      empty_q   <= 1'b1;
      r_valid_q <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      r_gptr_q  <= r_gptr_d;
      empty_q   <= empty_d;
      r_valid_q <= r_fire;
    end
  end

`ifdef FIFO_ALMOST_EMPTY_EN
  localparam logic [ADDR_W:0] AE_LVL = PW'(AE_THRESH);

  logic [ADDR_W:0] wbin_s;
  logic [ADDR_W:0] level_d;
  logic            almost_empty_q;
  logic            almost_empty_d;

  assign almost_empty = almost_empty_q;

  // Gray-to-binary of the synchronized write pointer; level is modulo the extended pointer width.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wbin_s[i] = ^(wq2_q >> i);
    end
    level_d        = wbin_s - rbin_d;
    almost_empty_d = (level_d <= AE_LVL);
  end

  // Almost-empty flag register; comes out of reset asserted like empty.
  always_ff @(posedge r_clk or negedge resetn) begin
    if (!resetn) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= almost_empty_d;
    end
  end
`else
  // Feature compiled out: the port stays, tied low; the threshold only appears in a constant term.
  assign almost_empty = 1'b0 & (AE_THRESH < 0);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl with read-address scoreboard
module tb_fifo_rd_ctrl;

  localparam int AW = 3;
  localparam int AE = 2;

  logic          r_clk;
  logic          resetn;
  logic          r_en;
  logic [AW:0]   w_gptr;
  logic [AW-1:0] r_adrs;
  logic          r_fire;
  logic [AW:0]   r_gptr;
  logic          empty;
  logic          r_valid;
  logic          almost_empty;

  fifo_rd_ctrl #(.ADDR_W(AW), .AE_THRESH(AE)) dut (
    .r_clk        (r_clk),
    .resetn       (resetn),
    .r_en         (r_en),
    .w_gptr       (w_gptr),
    .r_adrs       (r_adrs),
    .r_fire       (r_fire),
    .r_gptr       (r_gptr),
    .empty        (empty),
    .r_valid      (r_valid),
    .almost_empty (almost_empty)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int checks;
  int errors;

  logic [AW:0]   m_rbin, m_wq1, m_wq2, m_gptr, m_wbin;
  logic          m_empty, m_valid, m_ae;
  logic [AW-1:0] exp_q[$];
  logic          obs_fire;
  logic [AW-1:0] obs_adrs;

`ifdef FIFO_ALMOST_EMPTY_EN
  localparam logic AE_ON = 1'b1;
`else
  localparam logic AE_ON = 1'b0;
`endif

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] r;
    r[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  task automatic model_reset();
    m_rbin  = '0;
    m_wq1   = '0;
    m_wq2   = '0;
    m_gptr  = '0;
    m_empty = 1'b1;
    m_valid = 1'b0;
    m_ae    = AE_ON;
  endtask

  // One clock: entered and left at posedge+1, where inputs are driven.
  task automatic cycle();
    logic          fire_exp;
    logic [AW:0]   nxt;
    logic [AW-1:0] ea;
`ifdef FIFO_ALMOST_EMPTY_EN
    logic [AW:0]   lvl;
`endif
    #1;
    fire_exp = r_en && !m_empty;
    obs_fire = r_fire;
    obs_adrs = r_adrs;
    checks++;
    if (r_fire !== fire_exp) begin
      errors++;
      $display("FAIL r_fire got %b exp %b t=%0t", r_fire, fire_exp, $time);
    end
    checks++;
    if (r_adrs !== m_rbin[AW-1:0]) begin
      errors++;
      $display("FAIL r_adrs got %0d exp %0d t=%0t", r_adrs, m_rbin[AW-1:0], $time);
    end
    if (fire_exp) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got read at %0d exp none t=%0t", r_adrs, $time);
      end else begin
        ea = exp_q.pop_front();
        if (r_adrs !== ea) begin
          errors++;
          $display("FAIL sb_adrs got %0d exp %0d t=%0t", r_adrs, ea, $time);
        end
      end
    end
    @(posedge r_clk);
    if (!resetn) begin
      model_reset();
    end else begin
      nxt = m_rbin + {{AW{1'b0}}, fire_exp};
`ifdef FIFO_ALMOST_EMPTY_EN
      lvl  = g2b(m_wq2) - nxt;
      m_ae = (int'(lvl) <= AE);
`endif
      m_empty = (gray(nxt) == m_wq2);
      m_gptr  = gray(nxt);
      m_valid = fire_exp;
      m_rbin  = nxt;
      m_wq2   = m_wq1;
      m_wq1   = w_gptr;
    end
    #1;
    checks++;
    if (r_gptr !== m_gptr) begin
      errors++;
      $display("FAIL r_gptr got %b exp %b t=%0t", r_gptr, m_gptr, $time);
    end
    checks++;
    if (empty !== m_empty) begin
      errors++;
      $display("FAIL empty got %b exp %b t=%0t", empty, m_empty, $time);
    end
    checks++;
    if (r_valid !== m_valid) begin
      errors++;
      $display("FAIL r_valid got %b exp %b t=%0t", r_valid, m_valid, $time);
    end
    checks++;
    if (almost_empty !== m_ae) begin
      errors++;
      $display("FAIL almost_empty got %b exp %b t=%0t", almost_empty, m_ae, $time);
    end
  endtask

  task automatic write_n(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(m_wbin[AW-1:0]);
      m_wbin = m_wbin + 1'b1;
    end
    w_gptr = gray(m_wbin);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    r_en   = 1'b0;
    w_gptr = '0;
    m_wbin = '0;
    exp_q.delete();
    model_reset();
    cycle();
    cycle();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    r_en   = 1'b1;
    w_gptr = '0;
    m_wbin = '0;
    exp_q.delete();
    model_reset();
    @(posedge r_clk);
    #1;
    checks++;
    if (empty !== 1'b1 || r_fire !== 1'b0 || r_adrs !== '0 || r_gptr !== '0) begin
      errors++;
      $display("FAIL reset_state got e=%b f=%b a=%0d g=%b exp e=1 f=0 a=0 g=0", empty, r_fire, r_adrs, r_gptr);
    end
    repeat (2) cycle();
    resetn = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic test_single_write();
    int lat;
    apply_reset();
    r_en = 1'b0;
    write_n(1);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      cycle();
      if (empty === 1'b0) lat = c;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL empty_latency got %0d exp 3", lat);
    end
    r_en = 1'b1;
    cycle();
    checks++;
    if (obs_fire !== 1'b1 || obs_adrs !== 3'd0) begin
      errors++;
      $display("FAIL single_read got f=%b a=%0d exp f=1 a=0", obs_fire, obs_adrs);
    end
    checks++;
    if (r_gptr !== 4'b0001 || empty !== 1'b1 || r_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_after got g=%b e=%b v=%b exp g=0001 e=1 v=1", r_gptr, empty, r_valid);
    end
    r_en = 1'b0;
    cycle();
  endtask

  task automatic test_burst_drain();
    int fires, valids, rise_at;
    apply_reset();
    r_en = 1'b1;
    write_n(5);
    fires = 0;
    valids = 0;
    rise_at = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (obs_fire === 1'b1) begin
        fires++;
        if (empty === 1'b1 && rise_at == 0) rise_at = fires;
      end
      if (r_valid === 1'b1) valids++;
    end
    checks++;
    if (fires != 5) begin
      errors++;
      $display("FAIL burst_fires got %0d exp 5", fires);
    end
    checks++;
    if (valids != 5) begin
      errors++;
      $display("FAIL burst_valids got %0d exp 5", valids);
    end
    checks++;
    if (rise_at != 5) begin
      errors++;
      $display("FAIL burst_empty_rise got %0d exp 5", rise_at);
    end
  endtask

  task automatic test_wrap();
    int          chunks[3] = '{8, 8, 4};
    int          n, wrapped, bad_gray;
    logic [AW:0] prev_g;
    logic [AW-1:0] prev_a;
    logic        have_prev;
    apply_reset();
    r_en = 1'b1;
    wrapped = 0;
    bad_gray = 0;
    have_prev = 1'b0;
    prev_a = '0;
    prev_g = r_gptr;
    for (int k = 0; k < 3; k++) begin
      write_n(chunks[k]);
      n = 0;
      for (int c = 0; c < 14; c++) begin
        cycle();
        if ($countones(r_gptr ^ prev_g) > 1) bad_gray++;
        prev_g = r_gptr;
        if (obs_fire === 1'b1) begin
          n++;
          if (have_prev && prev_a == 3'd7 && obs_adrs == 3'd0) wrapped++;
          prev_a = obs_adrs;
          have_prev = 1'b1;
        end
      end
      checks++;
      if (n != chunks[k]) begin
        errors++;
        $display("FAIL wrap_chunk%0d got %0d exp %0d", k, n, chunks[k]);
      end
    end
    checks++;
    if (wrapped != 2) begin
      errors++;
      $display("FAIL wrap_adrs got %0d exp 2", wrapped);
    end
    checks++;
    if (bad_gray != 0) begin
      errors++;
      $display("FAIL gray_step got %0d exp 0", bad_gray);
    end
    checks++;
    if (r_gptr !== 4'b0110 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_final got g=%b e=%b exp g=0110 e=1", r_gptr, empty);
    end
  endtask

  task automatic test_almost_empty();
    apply_reset();
    r_en = 1'b0;
    write_n(4);
    repeat (4) cycle();
    checks++;
    if (almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL ae_level4 got %b exp 0", almost_empty);
    end
    r_en = 1'b1;
    cycle();
    checks++;
    if (almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL ae_level3 got %b exp 0", almost_empty);
    end
    cycle();
    checks++;
    if (almost_empty !== AE_ON) begin
      errors++;
      $display("FAIL ae_level2 got %b exp %b", almost_empty, AE_ON);
    end
    repeat (4) cycle();
    checks++;
    if (almost_empty !== AE_ON) begin
      errors++;
      $display("FAIL ae_drained got %b exp %b", almost_empty, AE_ON);
    end
  endtask

  task automatic test_mid_reset();
    int fires;
    apply_reset();
    r_en = 1'b1;
    write_n(6);
    fires = 0;
    for (int c = 0; c < 12 && fires < 3; c++) begin
      cycle();
      if (obs_fire === 1'b1) fires++;
    end
    checks++;
    if (fires != 3 || r_adrs !== 3'd3) begin
      errors++;
      $display("FAIL mid_setup got fires=%0d a=%0d exp fires=3 a=3", fires, r_adrs);
    end
    resetn = 1'b0;
    w_gptr = '0;
    m_wbin = '0;
    exp_q.delete();
    model_reset();
    #1;
    checks++;
    if (empty !== 1'b1 || r_gptr !== '0 || r_valid !== 1'b0 || r_fire !== 1'b0 || r_adrs !== '0) begin
      errors++;
      $display("FAIL mid_async got e=%b g=%b v=%b f=%b a=%0d exp e=1 g=0 v=0 f=0 a=0",
               empty, r_gptr, r_valid, r_fire, r_adrs);
    end
    cycle();
    checks++;
    if (r_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_valid got %b exp 0", r_valid);
    end
    resetn = 1'b1;
    repeat (4) cycle();
    checks++;
    if (r_gptr !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_release got g=%b e=%b exp g=0 e=1", r_gptr, empty);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_burst_drain();
    test_wrap();
    test_almost_empty();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
